// File: rtl/pipe_skid_if.sv
// ---------------------------------------------------------------------------
// pipe_skid_if
// Valid/ready stream bundle for one pipe_skid_reg stage: the upstream
// (in_*) channel and the downstream (out_*) channel.
//
//   in_valid  : upstream offers in_data
//   in_ready  : stage accepts in_data this cycle
//   in_data   : upstream payload, DATA_W bits
//   out_valid : out_data holds a live entry
//   out_ready : downstream accepts out_data this cycle
//   out_data  : payload presented downstream, DATA_W bits
//
// Modports:
//   slave  - the register stage itself (consumes in_*, produces out_*)
//   master - the environment around it (produces in_*, consumes out_*)
// ---------------------------------------------------------------------------
interface pipe_skid_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
// Two-entry pipeline register with a skid buffer. The main entry drives the
// downstream channel directly from flops; the skid entry catches the beat
// that was already in flight when downstream backpressure appeared, so
// in_ready can be a registered signal (apart from stall/flush gating).
// Supports a global freeze (stall) and a pipeline kill (flush) that loads a
// NOP payload into the main entry and counts discarded live entries.
//
// Ports:
//   clk         : sole clock, rising edge
//   rst         : asynchronous, active-high reset; clears all state
//   stall       : freeze; every register holds
//   flush       : kill all buffered entries (ignored while stall=1)
//   bus         : pipe_skid_if.slave stream bundle (in_* / out_*)
//   occupancy   : live entries held, 0..2
//   discard_cnt : saturating count of live entries killed by flush
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_VALUE = DATA_W'(32'h00000013),
    parameter int                 CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    pipe_skid_if.slave       bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] discard_cnt
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;

    logic in_fire;
    logic out_fire;
    logic main_free;

    // Add 0..2 discarded entries to the counter, clamping at all-ones.
    // One extra bit is enough because the increment never exceeds 2 and the
    // counter never exceeds its own maximum.
    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] cnt,
        input logic [1:0]       inc
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        if (sum[CNT_W]) begin
            return '1;
        end
        return sum[CNT_W-1:0];
    endfunction

    // A full skid entry is the only registered reason to refuse a beat;
    // stall and flush gate it combinationally so no beat is taken on a cycle
    // where it would be frozen out or killed.
    assign bus.in_ready = !skid_valid && !stall && !flush;

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign out_fire  = main_valid && bus.out_ready && !stall;
    assign main_free = !main_valid || out_fire;

    // Outputs come straight from the main entry: no in-to-out comb path.
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign occupancy     = {1'b0, main_valid} + {1'b0, skid_valid};

    // Main/skid entries and discard counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid  <= 1'b0;
            main_data   <= '0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            discard_cnt <= '0;
        end else if (!stall) begin
            if (flush) begin
                // skid_data is left alone: its valid bit is what matters.
                main_valid  <= 1'b0;
                skid_valid  <= 1'b0;
                main_data   <= NOP_VALUE;
                discard_cnt <= sat_add(discard_cnt, occupancy);
            end else if (main_free) begin
                // The skid beat is older than anything arriving now, so it
                // goes first; in_ready is low while skid is full, so no new
                // beat can be accepted on this edge in that case.
                if (skid_valid) begin
                    main_data  <= skid_data;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (in_fire) begin
                    main_data  <= bus.in_data;
                    main_valid <= 1'b1;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (in_fire) begin
                // Main is blocked downstream: park the in-flight beat.
                skid_data  <= bus.in_data;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
// Self-checking bench for pipe_skid_reg (DATA_W=32, CNT_W=2). Expected
// payloads are pushed to a queue when a beat is accepted upstream and popped
// and compared when the DUT hands a beat downstream.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic             flush;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] discard_cnt;

    pipe_skid_if #(.DATA_W(DATA_W)) bus ();

    pipe_skid_reg #(
        .DATA_W    (DATA_W),
        .NOP_VALUE (32'h00000013),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .bus         (bus),
        .occupancy   (occupancy),
        .discard_cnt (discard_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Scoreboard state
    logic [31:0] exp_q[$];
    logic        popped;
    logic        under;
    logic [31:0] exp_v;
    logic [31:0] got_v;
    int          pops;

    // Apply one cycle of stimulus at the falling edge, let in_ready settle,
    // then update the scoreboard for the rising edge that follows.
    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy,
                         input logic stl, input logic fl);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        stall         = stl;
        flush         = fl;
        #1;
        popped = 1'b0;
        under  = 1'b0;
        if (!stl) begin
            if (fl) begin
                exp_q.delete();
            end else begin
                if (bus.out_valid && ordy) begin
                    if (exp_q.size() == 0) begin
                        under = 1'b1;
                    end else begin
                        exp_v  = exp_q.pop_front();
                        got_v  = bus.out_data;
                        popped = 1'b1;
                        pops++;
                    end
                end
                if (iv && bus.in_ready) exp_q.push_back(d);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        stall = 1'b0; flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        stall = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); else passed++;
        total++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy got=%0d want=0", occupancy); else passed++;
        total++; if (discard_cnt !== 2'd0) $display("FAIL reset_discard got=%0d want=0", discard_cnt); else passed++;
        total++; if (bus.out_data !== 32'h0) $display("FAIL reset_out_data got=%h want=0", bus.out_data); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); else passed++;
    endtask

    task automatic test_stream();
        logic [31:0] d [5] = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0};
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            drive(i < 3, d[i], 1'b1, 1'b0, 1'b0);
            if (popped) begin
                total++; if (got_v !== exp_v) $display("FAIL stream_data got=%h want=%h", got_v, exp_v); else passed++;
            end
            if (under) begin
                total++; $display("FAIL stream_extra_beat got=%h want=none", bus.out_data);
            end
            total++; if (bus.out_valid !== (i >= 1 && i <= 3)) $display("FAIL stream_out_valid cyc=%0d got=%b want=%b", i, bus.out_valid, (i >= 1 && i <= 3)); else passed++;
            total++; if (occupancy > 2'd1) $display("FAIL stream_occupancy got=%0d want<=1", occupancy); else passed++;
        end
        total++; if (pops !== 3) $display("FAIL stream_beats got=%0d want=3", pops); else passed++;
    endtask

    task automatic test_backpressure();
        pops = 0;
        drive(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hA3, 1'b0, 1'b0, 1'b0);
        total++; if (occupancy !== 2'd2) $display("FAIL bp_occupancy got=%0d want=2", occupancy); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_low got=%b want=0", bus.in_ready); else passed++;
        drive(1'b1, 32'hA3, 1'b0, 1'b0, 1'b0);
        // Skid full and out_fire together: skid moves, A3 must stay upstream.
        for (int i = 0; i < 5; i++) begin
            drive(i < 2, 32'hA3, 1'b1, 1'b0, 1'b0);
            if (i == 0) begin
                total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_no_accept_on_drain got=%b want=0", bus.in_ready); else passed++;
            end
            if (i == 1) begin
                total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_in_ready_reassert got=%b want=1", bus.in_ready); else passed++;
            end
            if (popped) begin
                total++; if (got_v !== exp_v) $display("FAIL bp_order got=%h want=%h", got_v, exp_v); else passed++;
            end
            if (under) begin
                total++; $display("FAIL bp_extra_beat got=%h want=none", bus.out_data);
            end
        end
        total++; if (pops !== 3) $display("FAIL bp_beats got=%0d want=3", pops); else passed++;
        total++; if (occupancy !== 2'd0) $display("FAIL bp_drained got=%0d want=0", occupancy); else passed++;
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hB2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hB3, 1'b0, 1'b0, 1'b1);
        total++; if (occupancy !== 2'd2) $display("FAIL flush_pre_occupancy got=%0d want=2", occupancy); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready got=%b want=0", bus.in_ready); else passed++;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid got=%b want=0", bus.out_valid); else passed++;
        total++; if (bus.out_data !== 32'h13) $display("FAIL flush_nop got=%h want=00000013", bus.out_data); else passed++;
        total++; if (occupancy !== 2'd0) $display("FAIL flush_occupancy got=%0d want=0", occupancy); else passed++;
        total++; if (discard_cnt !== 2'd2) $display("FAIL flush_discard got=%0d want=2", discard_cnt); else passed++;
    endtask

    task automatic test_stall_flush();
        do_reset();
        drive(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hC2, 1'b1, 1'b1, 1'b1);
        total++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b want=0", bus.in_ready); else passed++;
        total++; if (popped !== 1'b0) $display("FAIL stall_out_fire got=%b want=0", popped); else passed++;
        drive(1'b1, 32'hC2, 1'b1, 1'b1, 1'b1);
        total++; if (bus.out_valid !== 1'b1) $display("FAIL stall_hold_valid got=%b want=1", bus.out_valid); else passed++;
        total++; if (bus.out_data !== 32'hC1) $display("FAIL stall_hold_data got=%h want=000000c1", bus.out_data); else passed++;
        total++; if (occupancy !== 2'd1) $display("FAIL stall_hold_occupancy got=%0d want=1", occupancy); else passed++;
        total++; if (discard_cnt !== 2'd0) $display("FAIL stall_hold_discard got=%0d want=0", discard_cnt); else passed++;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++; if (occupancy !== 2'd0) $display("FAIL unstall_flush_occupancy got=%0d want=0", occupancy); else passed++;
        total++; if (discard_cnt !== 2'd1) $display("FAIL unstall_flush_discard got=%0d want=1", discard_cnt); else passed++;
    endtask

    task automatic test_saturate();
        logic [1:0] want [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hD0 + i, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            total++; if (discard_cnt !== want[i]) $display("FAIL sat_discard n=%0d got=%0d want=%0d", i, discard_cnt, want[i]); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'hE1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hE2, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++; if (occupancy !== 2'd2) $display("FAIL rmid_pre_occupancy got=%0d want=2", occupancy); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_out_valid got=%b want=0", bus.out_valid); else passed++;
        total++; if (occupancy !== 2'd0) $display("FAIL rmid_occupancy got=%0d want=0", occupancy); else passed++;
        total++; if (discard_cnt !== 2'd0) $display("FAIL rmid_discard got=%0d want=0", discard_cnt); else passed++;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        pops = 0;
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0), 1'b0, 1'b0);
            if (popped) begin
                total++; if (got_v !== exp_v) $display("FAIL b2b_data cyc=%0d got=%h want=%h", i, got_v, exp_v); else passed++;
            end
            if (under) begin
                total++; $display("FAIL b2b_extra_beat cyc=%0d got=%h want=none", i, bus.out_data);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            if (popped) begin
                total++; if (got_v !== exp_v) $display("FAIL b2b_drain got=%h want=%h", got_v, exp_v); else passed++;
            end
            if (under) begin
                total++; $display("FAIL b2b_drain_extra got=%h want=none", bus.out_data);
            end
        end
        total++; if (exp_q.size() !== 0) $display("FAIL b2b_lost_beats got=%0d want=0", exp_q.size()); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_empty got=%b want=0", bus.out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_stall_flush();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width in bits (min 1).
REQ-002 SHALL have parameter NOP_VALUE, default 32'h00000013: payload loaded into the output register on flush.
REQ-003 SHALL have parameter CNT_W, default 8: width of the discard counter.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high; clears all state immediately.
REQ-006 stall  input  1  freeze; all state holds.
REQ-007 flush  input  1  kill all buffered entries.
REQ-008 in_valid  input  1  upstream offers in_data.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 in_data  input  DATA_W  upstream payload.
REQ-011 out_valid  output  1  out_data holds a live entry.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 out_data  output  DATA_W  payload from the main register.
REQ-014 occupancy  output  2  live entries held, 0..2.
REQ-015 discard_cnt  output  CNT_W  saturating count of live entries killed by flush.

Function
REQ-016 SHALL hold two entries: main (drives out_*) and skid (catches the in-flight beat on backpressure), each with a valid bit.
REQ-017 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready & !stall.
REQ-018 in_ready SHALL be !skid_valid & !stall & !flush; it is combinational on stall/flush and registered otherwise.
REQ-019 out_valid SHALL equal main_valid and out_data SHALL equal main_data; no combinational in-to-out path.
REQ-020 Priority per edge SHALL be: rst > stall > flush > normal.
REQ-021 stall=1: main, skid, occupancy and discard_cnt hold; flush is ignored that cycle.
REQ-022 flush=1 (no stall): main_valid<=0, skid_valid<=0, main_data<=NOP_VALUE, skid_data holds; in_data that cycle is dropped; discard_cnt += number of live entries (0..2), saturating at 2^CNT_W-1.
REQ-023 Normal, main empty or out_fire: if skid_valid then main<=skid and skid_valid<=0; else if in_fire then main<=in_data, main_valid<=1; else main_valid<=0 and main_data holds.
REQ-024 Normal, main full and no out_fire: if in_fire then skid<=in_data, skid_valid<=1; main holds.
REQ-025 Latency in_fire to out_valid SHALL be exactly 1 cycle when both entries are empty; sustained throughput 1 beat/cycle with out_ready=1.
REQ-026 Ordering SHALL be strict FIFO; no beat is duplicated or lost except by flush.
REQ-027 occupancy SHALL equal main_valid + skid_valid.
REQ-028 in_ready SHALL deassert the cycle after skid fills and reassert the cycle after skid drains to main.
REQ-029 With the skid full and out_fire on the same edge, skid SHALL move to main and no new beat SHALL be accepted that edge.

Reset
REQ-030 On rst=1, asynchronously: main_valid=0, skid_valid=0, main_data=0, skid_data=0, occupancy=0, discard_cnt=0; out_valid=0 and in_ready=1 (if stall=0 and flush=0) from the first edge after release.
REQ-031 Reset mid-transfer SHALL discard all entries without incrementing discard_cnt.

Verification
REQ-032 Empty, out_ready=1, send 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on the next three cycles, occupancy never >1.
REQ-033 out_ready=0, send 0xA1,0xA2 -> occupancy 2, in_ready=0 next cycle, 0xA3 held upstream; raise out_ready -> outputs 0xA1,0xA2,0xA3 in order.
REQ-034 Occupancy 2, flush=1 for one cycle -> out_valid=0, out_data=0x00000013, occupancy 0, discard_cnt +2.
REQ-035 Occupancy 1, stall=1 and flush=1 together -> all state unchanged, in_ready=0; drop stall with flush=1 -> flush takes effect, discard_cnt +1.
REQ-036 CNT_W=2, four flushes of one live entry each -> discard_cnt 1,2,3,3 (saturates).
REQ-037 rst asserted with occupancy 2 -> out_valid=0, occupancy 0, discard_cnt 0 before the next edge.
